// File: rtl/stepper_ctrl_multi.sv
// Multi-channel stepper pulse generator: per-channel step counter, direction latch and done strobe.
// Optional per-channel abort input is enabled by defining STEPPER_CTRL_ABORT_EN.
module stepper_ctrl_multi #(
  parameter int NUM_CH  = 2,
  parameter int COUNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clk_en,
  input  logic [NUM_CH-1:0]         trigger,
  input  logic [NUM_CH*COUNT_W-1:0] num_steps,
  input  logic [NUM_CH-1:0]         dir_in,
`ifdef STEPPER_CTRL_ABORT_EN
  input  logic [NUM_CH-1:0]         abort,
`endif
  output logic [NUM_CH-1:0]         step_out,
  output logic [NUM_CH-1:0]         dir_out,
  output logic [NUM_CH-1:0]         working,
  output logic [NUM_CH-1:0]         done,
  output logic                      all_idle
);

  typedef enum logic [1:0] {
    STANDBY    = 2'b00,
    PULSE_HIGH = 2'b01,
    PULSE_LOW  = 2'b10
  } state_t;

  logic [NUM_CH-1:0] abort_req;

`ifdef STEPPER_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [COUNT_W-1:0] request;
    logic               step_q, dir_q, working_q, done_q;
    logic               dir_d, done_d;

    assign request = num_steps[i*COUNT_W +: COUNT_W];

    always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d     = state_q;
      remaining_d = remaining_q;
      dir_d       = dir_q;
      done_d      = 1'b0;

      case (state_q)
        STANDBY: begin
          if (clk_en && trigger[i]) begin
            dir_d = dir_in[i];
            if (request != '0) begin
              remaining_d = request;
              state_d     = PULSE_HIGH;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        PULSE_HIGH: begin
          if (clk_en) begin
            if (abort_req[i]) begin
              remaining_d = '0;
              state_d     = STANDBY;
              done_d      = 1'b1;
            end else begin
              state_d = PULSE_LOW;
            end
          end
        end
        PULSE_LOW: begin
          if (clk_en) begin
            if (abort_req[i]) begin
              remaining_d = '0;
              state_d     = STANDBY;
              done_d      = 1'b1;
            end else if (remaining_q <= COUNT_W'(1)) begin
              // A zero count here can only come from corruption; finish rather than wrap.
              remaining_d = '0;
              state_d     = STANDBY;
              done_d      = 1'b1;
            end else begin
              remaining_d = remaining_q - COUNT_W'(1);
              state_d     = PULSE_HIGH;
            end
          end
        end
        default: begin
          remaining_d = '0;
          state_d     = STANDBY;
        end
      endcase
    end

    // Outputs are loaded from next-state values so they change on the transition edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q     <= STANDBY;
        remaining_q <= '0;
        step_q      <= 1'b0;
        dir_q       <= 1'b0;
        working_q   <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        state_q     <= state_d;
        remaining_q <= remaining_d;
        step_q      <= (state_d == PULSE_HIGH);
        dir_q       <= dir_d;
        working_q   <= (state_d == PULSE_HIGH) || (state_d == PULSE_LOW);
        done_q      <= done_d;
      end
    end

    assign step_out[i] = step_q;
    assign dir_out[i]  = dir_q;
    assign working[i]  = working_q;
    assign done[i]     = done_q;
  end

  assign all_idle = ~|working;

endmodule

// File: tb/tb_stepper_ctrl_multi.sv
// Self-checking bench for stepper_ctrl_multi: directed scenarios plus random traffic
// compared against a tick-arithmetic reference model.
module tb_stepper_ctrl_multi;

  localparam int NUM_CH  = 2;
  localparam int COUNT_W = 4;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      clk_en;
  logic [NUM_CH-1:0]         trigger;
  logic [NUM_CH*COUNT_W-1:0] num_steps;
  logic [NUM_CH-1:0]         dir_in;
`ifdef STEPPER_CTRL_ABORT_EN
  logic [NUM_CH-1:0]         abort;
`endif
  logic [NUM_CH-1:0]         step_out, dir_out, working, done;
  logic                      all_idle;

  stepper_ctrl_multi #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .trigger   (trigger),
    .num_steps (num_steps),
    .dir_in    (dir_in),
`ifdef STEPPER_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .step_out  (step_out),
    .dir_out   (dir_out),
    .working   (working),
    .done      (done),
    .all_idle  (all_idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a move of N steps started on tick s is active while the tick
  // count lies in [s, s+2N); step is high on even offsets; done follows tick s+2N.
  int tick_cnt;
  int m_start  [NUM_CH];
  int m_n      [NUM_CH];
  bit m_active [NUM_CH];
  bit m_dir    [NUM_CH];
  bit m_done   [NUM_CH];

  int pulses    [NUM_CH];
  int high_clks [NUM_CH];
  int dones     [NUM_CH];
  bit prev_step [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tick_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_start[i] = 0; m_n[i] = 0; m_active[i] = 0; m_dir[i] = 0; m_done[i] = 0;
      prev_step[i] = 0;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NUM_CH; i++) begin
      pulses[i] = 0; high_clks[i] = 0; dones[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit en;
    bit ab;
    int n;
    en = clk_en;
    if (en) tick_cnt++;
    for (int i = 0; i < NUM_CH; i++) begin
      m_done[i] = 0;
`ifdef STEPPER_CTRL_ABORT_EN
      ab = abort[i];
`else
      ab = 0;
`endif
      if (en) begin
        if (m_active[i]) begin
          if (ab || (tick_cnt - m_start[i] == 2 * m_n[i])) begin
            m_active[i] = 0;
            m_done[i]   = 1;
          end
        end else if (trigger[i]) begin
          m_dir[i] = dir_in[i];
          n = int'(num_steps[i*COUNT_W +: COUNT_W]);
          if (n == 0) begin
            m_done[i] = 1;
          end else begin
            m_active[i] = 1;
            m_start[i]  = tick_cnt;
            m_n[i]      = n;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    bit any_active;
    bit exp_step;
    any_active = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_step = m_active[i] && (((tick_cnt - m_start[i]) % 2) == 0);
      any_active |= m_active[i];
      check($sformatf("step_out[%0d]", i), 32'(step_out[i]), 32'(exp_step));
      check($sformatf("dir_out[%0d]", i),  32'(dir_out[i]),  32'(m_dir[i]));
      check($sformatf("working[%0d]", i),  32'(working[i]),  32'(m_active[i]));
      check($sformatf("done[%0d]", i),     32'(done[i]),     32'(m_done[i]));
    end
    check("all_idle", 32'(all_idle), 32'(!any_active));
  endtask

  // One clk cycle: inputs are held from the previous falling edge, outputs sampled on the next.
  task automatic cyc(input logic en);
    clk_en = en;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    for (int i = 0; i < NUM_CH; i++) begin
      if (step_out[i] && !prev_step[i]) pulses[i]++;
      if (step_out[i]) high_clks[i]++;
      if (done[i]) dones[i]++;
      prev_step[i] = step_out[i];
    end
  endtask

  task automatic tick(input int gap);
    repeat (gap - 1) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic set_ch(input int ch, input int n, input logic d);
    num_steps[ch*COUNT_W +: COUNT_W] = COUNT_W'(n);
    dir_in[ch] = d;
  endtask

  initial begin
    reset_n   = 1'b0;
    clk_en    = 1'b0;
    trigger   = '0;
    num_steps = '0;
    dir_in    = '0;
`ifdef STEPPER_CTRL_ABORT_EN
    abort     = '0;
`endif
    model_reset();
    clear_counts();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset step_out", 32'(step_out), 32'(0));
    check("reset dir_out",  32'(dir_out),  32'(0));
    check("reset working",  32'(working),  32'(0));
    check("reset done",     32'(done),     32'(0));
    check("reset all_idle", 32'(all_idle), 32'(1));
    reset_n = 1'b1;

    // Single move: 3 steps on ch0, tick every 4 clks
    clear_counts();
    trigger = 2'b01; set_ch(0, 3, 1'b1);
    tick(4);
    trigger = '0;
    repeat (7) tick(4);
    check("single pulses0",    32'(pulses[0]),    32'(3));
    check("single high_clks0", 32'(high_clks[0]), 32'(12));
    check("single dones0",     32'(dones[0]),     32'(1));
    check("single pulses1",    32'(pulses[1]),    32'(0));
    check("single dones1",     32'(dones[1]),     32'(0));

    // Zero steps on ch1
    clear_counts();
    trigger = 2'b10; set_ch(1, 0, 1'b1);
    tick(4);
    trigger = '0;
    tick(4);
    check("zero pulses1", 32'(pulses[1]),  32'(0));
    check("zero dones1",  32'(dones[1]),   32'(1));
    check("zero dir1",    32'(dir_out[1]), 32'(1));

    // Concurrent moves with an ignored re-trigger on ch0
    clear_counts();
    trigger = 2'b11; set_ch(0, 2, 1'b0); set_ch(1, 5, 1'b1);
    tick(2);
    trigger = '0;
    tick(2);
    trigger = 2'b01; set_ch(0, 7, 1'b1);
    tick(2);
    trigger = '0;
    repeat (10) tick(2);
    check("conc pulses0", 32'(pulses[0]), 32'(2));
    check("conc pulses1", 32'(pulses[1]), 32'(5));
    check("conc dones0",  32'(dones[0]),  32'(1));
    check("conc dones1",  32'(dones[1]),  32'(1));
    check("conc dir0",    32'(dir_out[0]), 32'(0));
    check("conc idle",    32'(all_idle),  32'(1));

    // Gating: trigger held with no tick
    trigger = 2'b01; set_ch(0, 4, 1'b1);
    repeat (10) cyc(1'b0);
    check("gate working0", 32'(working[0]), 32'(0));
    check("gate dir0",     32'(dir_out[0]), 32'(0));
    trigger = '0;

    // Async reset in PULSE_HIGH of a 10-step move
    trigger = 2'b01; set_ch(0, 10, 1'b1);
    tick(3);
    trigger = '0;
    tick(3); tick(3);
    check("pre-reset step0", 32'(step_out[0]), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("async step_out", 32'(step_out), 32'(0));
    check("async working",  32'(working),  32'(0));
    check("async done",     32'(done),     32'(0));
    check("async all_idle", 32'(all_idle), 32'(1));
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    clear_counts();
    trigger = 2'b01; set_ch(0, 1, 1'b0);
    tick(3);
    trigger = '0;
    repeat (3) tick(3);
    check("post-reset pulses0", 32'(pulses[0]), 32'(1));
    check("post-reset dones0",  32'(dones[0]),  32'(1));

`ifdef STEPPER_CTRL_ABORT_EN
    // Abort during the third pulse of a 10-step move
    clear_counts();
    trigger = 2'b01; set_ch(0, 10, 1'b1);
    tick(2);
    trigger = '0;
    repeat (4) tick(2);
    abort = 2'b01;
    tick(2);
    abort = '0;
    check("abort step0", 32'(step_out[0]), 32'(0));
    repeat (3) tick(2);
    check("abort pulses0", 32'(pulses[0]), 32'(3));
    check("abort dones0",  32'(dones[0]),  32'(1));
`endif

    // Max count move: 2^COUNT_W-1 steps, tick every clk
    clear_counts();
    trigger = 2'b01; set_ch(0, 15, 1'b1);
    tick(1);
    trigger = '0;
    repeat (32) tick(1);
    check("max pulses0", 32'(pulses[0]), 32'(15));
    check("max dones0",  32'(dones[0]),  32'(1));

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        trigger[i] = ($urandom % 4) == 0;
        set_ch(i, ($urandom % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
               logic'($urandom % 2));
`ifdef STEPPER_CTRL_ABORT_EN
        abort[i] = ($urandom % 16) == 0;
`endif
      end
      cyc(logic'(($urandom % 3) == 0));
    end
    trigger = '0;
`ifdef STEPPER_CTRL_ABORT_EN
    abort = '0;
`endif
    repeat (40) tick(1);
    check("final idle", 32'(all_idle), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_ctrl_multi.md
# stepper_ctrl_multi

Parametrised multi-channel stepper pulse generator. It drives NUM_CH independent stepper drivers, with one step/dir pair per channel. Each channel accepts a step count and direction on a trigger, emits exactly that many step pulses paced by the shared `clk_en` tick, then reports completion. It sits between the motion/command processor and the stepper driver pins, and generalises the single-channel standby/working controller with a built-in step counter, direction latch and done strobe.

## Interface
Parameters:
- NUM_CH, 2: number of independent stepper channels (≥1).
- COUNT_W, 16: width of the per-channel step counter; maximum request is 2^COUNT_W−1 steps.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- reset_n  in  1  asynchronous, active-low reset. Asserted low, it clears all state immediately. Release is synchronous to clk.
- clk_en  in  1  pacing tick, one clk wide; every channel state change happens only on edges with clk_en=1.
- trigger  in  NUM_CH  per-channel start request.
- num_steps  in  NUM_CH*COUNT_W  per-channel step count; channel i uses bits [i*COUNT_W +: COUNT_W].
- dir_in  in  NUM_CH  per-channel direction, latched at trigger.
- abort  in  NUM_CH  per-channel stop request; present only with STEPPER_CTRL_ABORT_EN.
- step_out  out  NUM_CH  registered step pulse to the driver.
- dir_out  out  NUM_CH  registered latched direction.
- working  out  NUM_CH  channel is in PULSE_HIGH or PULSE_LOW.
- done  out  NUM_CH  one-clk completion strobe.
- all_idle  out  1  AND of all ~working.

## Operation
- Each channel has an identical, independent FSM with states STANDBY, PULSE_HIGH and PULSE_LOW, plus a COUNT_W-bit `remaining` register.
- trigger, abort, num_steps and dir_in are sampled only on clk edges where clk_en=1. They are ignored on all other edges.
- STANDBY, trigger=1:
  - Latch dir_in into dir_out.
  - If num_steps≠0: load `remaining`=num_steps and go to PULSE_HIGH.
  - If num_steps=0: stay in STANDBY and pulse done.
- PULSE_HIGH, tick: go to PULSE_LOW.
- PULSE_LOW, tick:
  - `remaining` decrements by 1.
  - If the pre-decrement value was 1, go to STANDBY and pulse done.
  - Otherwise go to PULSE_HIGH.
- trigger while in PULSE_HIGH or PULSE_LOW is ignored. No queueing, and num_steps and dir_in are not re-latched.
- step_out=1 exactly while in PULSE_HIGH. working=1 in PULSE_HIGH and PULSE_LOW.
- dir_out changes only on an accepted trigger, so it is stable throughout a move.
- Channels never interact. Simultaneous triggers on several channels all start on the same tick.
- An illegal state encoding recovers to STANDBY on the next clk edge, with outputs forced to idle values.

## Timing
- Reset values: step_out=0, dir_out=0, working=0, done=0, all_idle=1, `remaining`=0, state STANDBY.
- All outputs are registered and change on the clk edge that performs the transition. There are no combinational paths from inputs to outputs, except all_idle, which is derived from registered working.
- A request of N steps (N≥1) accepted on tick T:
  - step_out is high for ticks T..T+1 and low for ticks T+1..T+2, repeating.
  - Each pulse lasts one tick period high and one tick period low.
  - The last low phase ends at tick T+2N. On that edge working falls and done rises.
- done is high for exactly one clk cycle, not one tick period. It clears on the next clk edge regardless of clk_en.
- A request of N=0 accepted on tick T: done is high for the single clk cycle after T. working, step_out and dir_out semantics are unchanged, except that dir_out updates.
- A re-trigger is accepted on the same tick edge that completes a move only if the channel is already in STANDBY before that edge. The earliest new start is therefore the tick after done.
- reset_n asserted mid-move: outputs go to their reset values asynchronously, with no done strobe.
- num_steps = 2^COUNT_W−1 must complete with no wrap. `remaining` never underflows.

## Configuration
- Macro STEPPER_CTRL_ABORT_EN.
- Defined: the abort port exists. On an abort=1 tick in PULSE_HIGH or PULSE_LOW:
  - step_out drops on that edge, `remaining` is cleared, the channel goes to STANDBY and done pulses.
  - Abort has priority over the normal transition.
  - Abort in STANDBY is ignored.
  - Abort and trigger together in STANDBY: trigger wins.
- Not defined: no abort port, and every move runs to completion.

## Test plan
- Single move: NUM_CH=2, clk_en every 4 clks, trigger ch0 with num_steps=3 and dir=1 → exactly 3 step_out pulses on ch0, each 4 clks high and 4 clks low. dir_out[0]=1 throughout. done[0] is one clk high at tick T+6. ch1 stays idle.
- Zero steps: trigger ch1 with num_steps=0 and dir=1 → no step_out pulse, working[1] stays 0, done[1] is one clk high, dir_out[1]=1.
- Concurrent moves and ignored re-trigger: trigger ch0 with 2 steps and ch1 with 5 steps on the same tick, then re-trigger ch0 with 7 mid-move → ch0 emits 2 pulses and ch1 emits 5, with rising edges aligned. all_idle rises only after ch1's done.
- Gating: hold trigger high with clk_en=0 for 10 clks → no state change. Transitions occur only on clk_en edges.
- Async reset mid-move: assert reset_n low in PULSE_HIGH of a 10-step move, between clk edges → step_out and working drop immediately and no done pulse. After release, a new 1-step trigger yields exactly 1 pulse.
- Abort (macro on): abort ch0 during the 3rd pulse of a 10-step move → step_out[0] is 0 from that edge, done[0] pulses once and the total pulse count is 3. A max-count move with COUNT_W=4 (15 steps) without abort yields exactly 15 pulses.
